nrs_est_reader: RTL

- Consumer end of the NRS generator/estimator handshake.
- Waits for NRS_gen_ready, then reads the 16-entry NRS bit register one address at a time.
- Maps consecutive bit pairs c(2m), c(2m+1) into 8 QPSK reference symbols and streams them to the channel-estimator core over a valid/ready interface.
- Pulses est_ack once all 8 symbols are accepted, so the generator can refill for the next slot.

---
 rtl/nrs_pkg.sv | 16 +
 rtl/nrs_qpsk_mapper.sv | 23 ++
 rtl/nrs_est_reader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/nrs_pkg.sv
// Shared constants and FSM encoding for the NRS estimator reader.
package nrs_pkg;
  localparam int unsigned WIDTH_REG_DEF     = 16;
  localparam int unsigned NRS_WIDTH_R_I_DEF = 16;
  localparam int          NRS_AMP           = 23170;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_E,
    FETCH_O,
    LOAD,
    EMIT,
    ACK,
    WAIT_LOW
  } state_t;
endpackage

// File: rtl/nrs_qpsk_mapper.sv
// Combinational QPSK mapper: bit pair to signed re/im of magnitude AMP.
// Define NRS_CONJ_EN to emit the conjugate (imag part negated).
module nrs_qpsk_mapper #(
  parameter int unsigned W   = 16,
  parameter int          AMP = 23170
) (
  input  logic                c_even,
  input  logic                c_odd,
  output logic signed [W-1:0] re,
  output logic signed [W-1:0] im
);
  localparam logic signed [W-1:0] POS = W'(AMP);
  localparam logic signed [W-1:0] NEG = -POS;

  always_comb begin
    re = c_even ? NEG : POS;
`ifdef NRS_CONJ_EN
    im = c_odd ? POS : NEG;
`else
    im = c_odd ? NEG : POS;
`endif
  end
endmodule

// File: rtl/nrs_est_reader.sv
// Reads the NRS bit register pairwise and streams QPSK reference symbols.
// Optional conjugate output via NRS_CONJ_EN (handled in nrs_qpsk_mapper).
module nrs_est_reader #(
  parameter int unsigned WIDTH_REG     = nrs_pkg::WIDTH_REG_DEF,
  parameter int unsigned LINES         = $clog2(WIDTH_REG),
  parameter int unsigned NRS_WIDTH_R_I = nrs_pkg::NRS_WIDTH_R_I_DEF,
  parameter int          NRS_AMP       = nrs_pkg::NRS_AMP
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            new_frame,
  input  logic                            NRS_gen_ready,
  input  logic                            nrs_bit,
  output logic [LINES-1:0]                rd_addr_est,
  output logic                            est_ack,
  output logic                            sym_valid,
  input  logic                            sym_ready,
  output logic signed [NRS_WIDTH_R_I-1:0] nrs_re,
  output logic signed [NRS_WIDTH_R_I-1:0] nrs_im,
  output logic [2:0]                      sym_idx,
  output logic                            sym_last,
  output logic                            busy
);
  import nrs_pkg::*;

  localparam int unsigned     MW     = LINES - 1;
  localparam logic [MW-1:0]   M_LAST = MW'(WIDTH_REG / 2 - 1);

  state_t                         state_q, state_d;
  logic [MW-1:0]                  m_q, m_d, m_inc;
  logic [LINES-1:0]               rd_addr_q, rd_addr_d;
  logic                           c_even_q, c_even_d;
  logic                           est_ack_q, est_ack_d;
  logic                           sym_valid_q, sym_valid_d;
  logic                           sym_last_q, sym_last_d;
  logic                           busy_q, busy_d;
  logic [2:0]                     sym_idx_q, sym_idx_d;
  logic signed [NRS_WIDTH_R_I-1:0] re_q, re_d, im_q, im_d;
  logic signed [NRS_WIDTH_R_I-1:0] map_re, map_im;

  nrs_qpsk_mapper #(
    .W   (NRS_WIDTH_R_I),
    .AMP (NRS_AMP)
  ) u_mapper (
    .c_even (c_even_q),
    .c_odd  (nrs_bit),
    .re     (map_re),
    .im     (map_im)
  );

  assign m_inc = m_q + 1'b1;

  // Address is set on entry to FETCH_E/FETCH_O so it is visible during those states.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    rd_addr_d   = rd_addr_q;
    c_even_d    = c_even_q;
    est_ack_d   = 1'b0;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    sym_idx_d   = sym_idx_q;
    re_d        = re_q;
    im_d        = im_q;
    if (new_frame) begin
      state_d     = IDLE;
      m_d         = '0;
      sym_valid_d = 1'b0;
      sym_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (NRS_gen_ready) begin
          state_d   = FETCH_E;
          m_d       = '0;
          rd_addr_d = '0;
        end
        FETCH_E: begin
          rd_addr_d = {m_q, 1'b1};
          state_d   = FETCH_O;
        end
        FETCH_O: begin
          c_even_d = nrs_bit;
          state_d  = LOAD;
        end
        LOAD: begin
          re_d        = map_re;
          im_d        = map_im;
          sym_idx_d   = 3'(m_q);
          sym_last_d  = (m_q == M_LAST);
          sym_valid_d = 1'b1;
          state_d     = EMIT;
        end
        EMIT: if (sym_ready) begin
          sym_valid_d = 1'b0;
          sym_last_d  = 1'b0;
          if (m_q == M_LAST) begin
            est_ack_d = 1'b1;
            state_d   = ACK;
          end else begin
            m_d       = m_inc;
            rd_addr_d = {m_inc, 1'b0};
            state_d   = FETCH_E;
          end
        end
        ACK:      state_d = WAIT_LOW;
        WAIT_LOW: if (!NRS_gen_ready) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      rd_addr_q   <= '0;
      c_even_q    <= 1'b0;
      est_ack_q   <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      sym_idx_q   <= '0;
      re_q        <= '0;
      im_q        <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      rd_addr_q   <= rd_addr_d;
      c_even_q    <= c_even_d;
      est_ack_q   <= est_ack_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      sym_idx_q   <= sym_idx_d;
      re_q        <= re_d;
      im_q        <= im_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_addr_est = rd_addr_q;
  assign est_ack     = est_ack_q;
  assign sym_valid   = sym_valid_q;
  assign sym_last    = sym_last_q;
  assign sym_idx     = sym_idx_q;
  assign nrs_re      = re_q;
  assign nrs_im      = im_q;
  assign busy        = busy_q;
endmodule
